// File: rtl/memory.sv
// rtl/memory.sv - rv32 memory-access stage: loads/stores over a single-outstanding data bus
// Optional MEMORY_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and complete as a trap record.
module memory (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        up_tvalid,
    output logic        up_tready,
    input  logic [3:0]  up_op,
    input  logic        up_br,
    input  logic [4:0]  up_rd,
    input  logic [31:0] up_alu,
    input  logic [31:0] up_rs2,
    output logic        down_tvalid,
    input  logic        down_tready,
    output logic [3:0]  down_op,
    output logic [4:0]  down_rd,
    output logic [31:0] down_res,
    output logic [31:0] bypass,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_strb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
`ifdef MEMORY_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam logic [3:0] OP_NULL = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_LHU  = 4'd6;
    localparam logic [3:0] OP_SB   = 4'd7;
    localparam logic [3:0] OP_SH   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  h_op;
    logic [4:0]  h_rd;
    logic [31:0] h_alu, h_rs2;
    logic        h_store;
    logic        accept, up_mem, up_mis;
    logic        load;
    logic [3:0]  ld_op;
    logic [4:0]  ld_rd;
    logic [31:0] ld_res;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic        unused_br;

    // branch flag is resolved upstream; it has no meaning in this stage
    assign unused_br = up_br;

    assign up_tready = (state == IDLE) & (~down_tvalid | down_tready);
    assign accept    = up_tvalid & up_tready;
    assign up_mem    = up_op inside {[OP_LB:OP_SW]};
    assign h_store   = h_op inside {OP_SB, OP_SH, OP_SW};

`ifdef MEMORY_MISALIGN_TRAP_EN
    always_comb begin
        up_mis = 1'b0;
        case (up_op)
            OP_LH, OP_LHU, OP_SH: up_mis = up_alu[0];
            OP_LW, OP_SW:         up_mis = |up_alu[1:0];
            default:              up_mis = 1'b0;
        endcase
    end
`else
    assign up_mis = 1'b0;
`endif

    // lane select ignores address bits finer than the access size
    assign rd_byte = dmem_rdata[{h_alu[1:0], 3'b000} +: 8];
    assign rd_half = h_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        rd_ext = dmem_rdata;
        case (h_op)
            OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  rd_ext = {24'h0, rd_byte};
            OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  rd_ext = {16'h0, rd_half};
            default: rd_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ld_op     = up_op;
        ld_rd     = up_rd;
        ld_res    = up_alu;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (up_mem & ~up_mis) begin
                        state_nxt = REQ;
                    end else begin
                        load = 1'b1;
                        if (up_mis) begin
                            ld_op = OP_NULL;
                            ld_rd = 5'd0;
                        end
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (h_store) begin
                        load      = 1'b1;
                        ld_op     = h_op;
                        ld_rd     = 5'd0;
                        ld_res    = h_alu;
                        state_nxt = OUT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    load      = 1'b1;
                    ld_op     = h_op;
                    ld_rd     = h_rd;
                    ld_res    = rd_ext;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (down_tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            h_op  <= OP_NULL;
            h_rd  <= 5'd0;
            h_alu <= 32'h0;
            h_rs2 <= 32'h0;
        end else if ((state == IDLE) && accept && up_mem && !up_mis) begin
            h_op  <= up_op;
            h_rd  <= up_rd;
            h_alu <= up_alu;
            h_rs2 <= up_rs2;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            down_tvalid <= 1'b0;
            down_op     <= OP_NULL;
            down_rd     <= 5'd0;
            down_res    <= 32'h0;
        end else if (load) begin
            down_tvalid <= 1'b1;
            down_op     <= ld_op;
            down_rd     <= ld_rd;
            down_res    <= ld_res;
        end else if (down_tready) begin
            down_tvalid <= 1'b0;
        end
    end

`ifdef MEMORY_MISALIGN_TRAP_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) misalign <= 1'b0;
        else          misalign <= (state == IDLE) & accept & up_mis;
    end
`endif

    assign bypass     = down_res;
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req & h_store;
    assign dmem_addr  = {h_alu[31:2], 2'b00};

    always_comb begin
        dmem_wdata = h_rs2;
        dmem_strb  = 4'b0000;
        case (h_op)
            OP_SB:   dmem_wdata = {4{h_rs2[7:0]}};
            OP_SH:   dmem_wdata = {2{h_rs2[15:0]}};
            default: dmem_wdata = h_rs2;
        endcase
        if (dmem_we) begin
            case (h_op)
                OP_SB:   dmem_strb = 4'b0001 << h_alu[1:0];
                OP_SH:   dmem_strb = h_alu[1] ? 4'b1100 : 4'b0011;
                default: dmem_strb = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - randomized self-checking bench for the memory stage
// Also covers the MEMORY_MISALIGN_TRAP_EN build when that macro is defined.
module tb_memory;

    localparam logic [3:0] OP_NULL = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_LB   = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_LHU  = 4'd6;
    localparam logic [3:0] OP_SB   = 4'd7;
    localparam logic [3:0] OP_SH   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;

`ifdef MEMORY_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        up_tvalid = 1'b0;
    logic        up_tready;
    logic [3:0]  up_op = 4'd0;
    logic        up_br = 1'b0;
    logic [4:0]  up_rd = 5'd0;
    logic [31:0] up_alu = 32'h0;
    logic [31:0] up_rs2 = 32'h0;
    logic        down_tvalid;
    logic        down_tready = 1'b0;
    logic [3:0]  down_op;
    logic [4:0]  down_rd;
    logic [31:0] down_res;
    logic [31:0] bypass;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_strb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        misalign;

    int n_checks = 0;
    int n_pass   = 0;

    memory dut (
        .aclk(aclk), .aresetn(aresetn),
        .up_tvalid(up_tvalid), .up_tready(up_tready), .up_op(up_op), .up_br(up_br),
        .up_rd(up_rd), .up_alu(up_alu), .up_rs2(up_rs2),
        .down_tvalid(down_tvalid), .down_tready(down_tready), .down_op(down_op),
        .down_rd(down_rd), .down_res(down_res), .bypass(bypass),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_strb(dmem_strb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
`ifdef MEMORY_MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

`ifndef MEMORY_MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit is_load(input logic [3:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic bit is_store(input logic [3:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic bit ref_mis(input logic [3:0] op, input logic [31:0] addr);
        int unsigned a;
        a = addr % 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return TRAP_EN && (a % 2 != 0);
        if (op == OP_LW || op == OP_SW) return TRAP_EN && (a != 0);
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        int unsigned a;
        logic [31:0] b, h;
        a = addr % 4;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 128) ? b - 32'h100 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32768) ? h - 32'h10000 : h;
            OP_LHU:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] rs2);
        case (op)
            OP_SB:   return (rs2 & 32'hFF) * 32'h0101_0101;
            OP_SH:   return (rs2 & 32'hFFFF) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] ref_strb(input logic [3:0] op, input logic [31:0] addr);
        int unsigned a;
        a = addr % 4;
        case (op)
            OP_SB:   return 32'(1 << a);
            OP_SH:   return (a >= 2) ? 32'hC : 32'h3;
            OP_SW:   return 32'hF;
            default: return 32'h0;
        endcase
    endfunction

    // one instruction end to end; gd/rvd/rdy are wait cycles before gnt, rvalid, down_tready
    task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] mem_word,
                          input int gd, input int rvd, input int rdy);
        logic [3:0]  e_op;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
        bit mis, mem;
        mis = ref_mis(op, alu);
        mem = (is_load(op) || is_store(op)) && !mis;
        check("up_tready idle", 32'(up_tready), 1);
        up_op = op; up_rd = rd; up_alu = alu; up_rs2 = rs2; up_br = 1'($urandom);
        up_tvalid = 1'b1;
        @(negedge aclk);
        up_tvalid = 1'b0;
        up_alu = $urandom;
        up_rs2 = $urandom;
        if (mem) begin
            for (int i = 0; i < gd; i++) begin
                check("req held", 32'(dmem_req), 1);
                check("addr held", dmem_addr, alu & ~32'h3);
                check("up_tready busy", 32'(up_tready), 0);
                check("down empty", 32'(down_tvalid), 0);
                dmem_rvalid = 1'($urandom);
                dmem_rdata = $urandom;
                @(negedge aclk);
            end
            dmem_rvalid = 1'b0;
            check("req", 32'(dmem_req), 1);
            check("addr", dmem_addr, alu & ~32'h3);
            check("we", 32'(dmem_we), 32'(is_store(op)));
            check("strb", 32'(dmem_strb), ref_strb(op, alu));
            if (is_store(op)) check("wdata", dmem_wdata, ref_wdata(op, rs2));
            dmem_gnt = 1'b1;
            @(negedge aclk);
            dmem_gnt = 1'b0;
            if (is_load(op)) begin
                for (int i = 0; i < rvd; i++) begin
                    check("req dropped", 32'(dmem_req), 0);
                    check("down empty resp", 32'(down_tvalid), 0);
                    dmem_gnt = 1'($urandom);
                    @(negedge aclk);
                end
                dmem_gnt = 1'b0;
                dmem_rdata = mem_word;
                dmem_rvalid = 1'b1;
                @(negedge aclk);
                dmem_rvalid = 1'b0;
                dmem_rdata = $urandom;
            end
        end else begin
            check("no req", 32'(dmem_req), 0);
        end
        e_op = mis ? OP_NULL : op;
        e_rd = (mis || is_store(op)) ? 5'd0 : rd;
        e_res = (mem && is_load(op)) ? ref_load(op, alu, mem_word) : alu;
        check("down_tvalid", 32'(down_tvalid), 1);
        check("down_op", 32'(down_op), 32'(e_op));
        check("down_rd", 32'(down_rd), 32'(e_rd));
        check("down_res", down_res, e_res);
        check("bypass", bypass, e_res);
        if (TRAP_EN) check("misalign", 32'(misalign), 32'(mis));
        for (int i = 0; i < rdy; i++) begin
            @(negedge aclk);
            check("stall tvalid", 32'(down_tvalid), 1);
            check("stall res", down_res, e_res);
            check("stall up_tready", 32'(up_tready), 0);
            check("stall req", 32'(dmem_req), 0);
            if (TRAP_EN) check("misalign pulse", 32'(misalign), 0);
        end
        down_tready = 1'b1;
        @(negedge aclk);
        down_tready = 1'b0;
        check("down drained", 32'(down_tvalid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rop;
        aresetn = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("rst tvalid", 32'(down_tvalid), 0);
        check("rst op", 32'(down_op), 32'(OP_NULL));
        check("rst rd", 32'(down_rd), 0);
        check("rst res", down_res, 0);
        check("rst bypass", bypass, 0);
        check("rst req", 32'(dmem_req), 0);
        check("rst we", 32'(dmem_we), 0);
        check("rst strb", 32'(dmem_strb), 0);
        check("rst misalign", 32'(misalign), 0);
        aresetn = 1'b1;
        @(negedge aclk);

        run_op(OP_ALU, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
        run_op(OP_LB, 5'd7, 32'h103, 32'h0, 32'h80AA_BBCC, 1, 0, 0);
        run_op(OP_SH, 5'd9, 32'h202, 32'hDEAD_BEEF, 32'h0, 0, 0, 1);
        run_op(OP_LHU, 5'd3, 32'h306, 32'h0, 32'h8001_7FFE, 3, 2, 2);
        run_op(OP_LW, 5'd4, 32'h101, 32'h0, 32'h1357_9BDF, 0, 1, 0);

        // reset while a load waits for its response
        up_op = OP_LW; up_rd = 5'd6; up_alu = 32'h40; up_tvalid = 1'b1;
        @(negedge aclk);
        up_tvalid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge aclk);
        dmem_gnt = 1'b0;
        aresetn = 1'b0;
        #1;
        check("rst resp req", 32'(dmem_req), 0);
        check("rst resp tvalid", 32'(down_tvalid), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge aclk);
        dmem_rvalid = 1'b0;
        check("late rvalid", 32'(down_tvalid), 0);
        check("late rvalid ready", 32'(up_tready), 1);

        // reset while the request is still pending, and with a record held downstream
        up_op = OP_SW; up_alu = 32'h80; up_tvalid = 1'b1;
        @(negedge aclk);
        up_tvalid = 1'b0;
        check("req before rst", 32'(dmem_req), 1);
        aresetn = 1'b0;
        #1;
        check("rst req async", 32'(dmem_req), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        up_op = OP_ALU; up_alu = 32'h55; up_tvalid = 1'b1;
        @(negedge aclk);
        up_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("rst tvalid async", 32'(down_tvalid), 0);
        check("rst bypass async", bypass, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        for (int n = 0; n < 200; n++) begin
            rop = 4'($urandom_range(0, 9));
            run_op(rop, 5'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
